// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, mux selects, states
// and the per-state control word decoder.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_DECODE    = 4'd2;
    localparam logic [3:0] ST_EXEC_R    = 4'd3;
    localparam logic [3:0] ST_WB_R      = 4'd4;
    localparam logic [3:0] ST_EXEC_I    = 4'd5;
    localparam logic [3:0] ST_WB_I      = 4'd6;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd7;
    localparam logic [3:0] ST_MEM_RD    = 4'd8;
    localparam logic [3:0] ST_MEM_WR    = 4'd9;
    localparam logic [3:0] ST_WB_MEM    = 4'd10;
    localparam logic [3:0] ST_BRANCH    = 4'd11;
    localparam logic [3:0] ST_BRANCH_NE = 4'd12;
    localparam logic [3:0] ST_JUMP      = 4'd13;
    localparam logic [3:0] ST_TRAP      = 4'd14;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_FETCH     = ST_FETCH,
        S_DECODE    = ST_DECODE,
        S_EXEC_R    = ST_EXEC_R,
        S_WB_R      = ST_WB_R,
        S_EXEC_I    = ST_EXEC_I,
        S_WB_I      = ST_WB_I,
        S_MEM_ADDR  = ST_MEM_ADDR,
        S_MEM_RD    = ST_MEM_RD,
        S_MEM_WR    = ST_MEM_WR,
        S_WB_MEM    = ST_WB_MEM,
        S_BRANCH    = ST_BRANCH,
        S_BRANCH_NE = ST_BRANCH_NE,
        S_JUMP      = ST_JUMP,
        S_TRAP      = ST_TRAP
    } state_e;

    // fetch_wr marks FETCH: IRWrite/PCWrite there are qualified by the memory ack.
    typedef struct packed {
        logic       pc_write;
        logic       fetch_wr;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctrl_t;

    function automatic ctrl_t ctrl_for_state(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.fetch_wr  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                c.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_WB_I: begin
                c.reg_write = 1'b1;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_WB_MEM: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_BRANCH, S_BRANCH_NE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALUOP_SUB;
                c.pc_source = PCSRC_ALUOUT;
                c.branch    = (s == S_BRANCH);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            S_TRAP: begin
                c.trap = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter: counts unacknowledged cycles of an access and flags expiry
// when the count reaches MEM_TIMEOUT with no ack (MEM_TIMEOUT = 0 never expires).
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tick_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i && !ack_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the limit cycle completes the access instead of expiring.
    assign expired_o = (MEM_TIMEOUT != 0) && tick_i && !ack_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory wait handshake, wait timeout and sticky traps.
// Define MC_CTRL_BNE_EN to support bne (opcode 000101) via a BranchNe_o output.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [OP_W-1:0]    Op_i,
    input  logic               mem_ack_i,
    output logic               PCWrite_o,
    output logic               Branch_o,
    output logic               IRWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IorD_o,
    output logic               RegDst_o,
    output logic               MemtoReg_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic [1:0]         PCSource_o,
`ifdef MC_CTRL_BNE_EN
    output logic               BranchNe_o,
`endif
    output logic               trap_o,
    output logic               illegal_o,
    output logic               timeout_o
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q,  ctrl_d;
    logic   illegal_q, illegal_d;
    logic   timeout_q, timeout_d;
    logic   mem_wait;
    logic   expired;
`ifdef MC_CTRL_BNE_EN
    logic   branch_ne_q, branch_ne_d;
`endif

    assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_d != state_q),
        .tick_i    (mem_wait),
        .ack_i     (mem_ack_i),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ack_i) begin
                    state_d = (state_q == S_FETCH)  ? S_DECODE :
                              (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (expired) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (Op_i == OP_W'(OP_RTYPE)) begin
                    state_d = S_EXEC_R;
                end else if (Op_i == OP_W'(OP_ADDI)) begin
                    state_d = S_EXEC_I;
                end else if ((Op_i == OP_W'(OP_LW)) || (Op_i == OP_W'(OP_SW))) begin
                    state_d = S_MEM_ADDR;
                end else if (Op_i == OP_W'(OP_BEQ)) begin
                    state_d = S_BRANCH;
                end else if (Op_i == OP_W'(OP_J)) begin
                    state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                end else if (Op_i == OP_W'(OP_BNE)) begin
                    state_d = S_BRANCH_NE;
`endif
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            // Opcode is looked at again here to pick the load or store path.
            S_MEM_ADDR: begin
                if (Op_i == OP_W'(OP_LW)) begin
                    state_d = S_MEM_RD;
                end else if (Op_i == OP_W'(OP_SW)) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_BRANCH_NE, S_JUMP: state_d = S_FETCH;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        ctrl_d = ctrl_for_state(state_d);
`ifdef MC_CTRL_BNE_EN
        branch_ne_d = (state_d == S_BRANCH_NE);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef MC_CTRL_BNE_EN
            branch_ne_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
`ifdef MC_CTRL_BNE_EN
            branch_ne_q <= branch_ne_d;
`endif
        end
    end

    assign PCWrite_o  = ctrl_q.pc_write | (ctrl_q.fetch_wr & mem_ack_i);
    assign IRWrite_o  = ctrl_q.fetch_wr & mem_ack_i;
    assign Branch_o   = ctrl_q.branch;
    assign MemRead_o  = ctrl_q.mem_read;
    assign MemWrite_o = ctrl_q.mem_write;
    assign IorD_o     = ctrl_q.iord;
    assign RegDst_o   = ctrl_q.reg_dst;
    assign MemtoReg_o = ctrl_q.mem_to_reg;
    assign RegWrite_o = ctrl_q.reg_write;
    assign ALUSrcA_o  = ctrl_q.alu_src_a;
    assign ALUSrcB_o  = ctrl_q.alu_src_b;
    assign ALUOp_o    = ALUOP_W'(ctrl_q.alu_op);
    assign PCSource_o = ctrl_q.pc_source;
    assign trap_o     = ctrl_q.trap;
    assign illegal_o  = illegal_q;
    assign timeout_o  = timeout_q;
`ifdef MC_CTRL_BNE_EN
    assign BranchNe_o = branch_ne_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, wait states,
// timeout, illegal-opcode trap and reset behaviour through the output control word.
module tb_multicycle_control;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [5:0] Op_i;
    logic       mem_ack_i;
    logic       PCWrite_o, Branch_o, IRWrite_o, MemRead_o, MemWrite_o, IorD_o;
    logic       RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o;
    logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
    logic       trap_o, illegal_o, timeout_o;
    logic       bne_obs;
`ifdef MC_CTRL_BNE_EN
    logic       BranchNe_o;
    assign bne_obs = BranchNe_o;
`else
    assign bne_obs = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    multicycle_control #(
        .OP_W        (6),
        .ALUOP_W     (2),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .Op_i       (Op_i),
        .mem_ack_i  (mem_ack_i),
        .PCWrite_o  (PCWrite_o),
        .Branch_o   (Branch_o),
        .IRWrite_o  (IRWrite_o),
        .MemRead_o  (MemRead_o),
        .MemWrite_o (MemWrite_o),
        .IorD_o     (IorD_o),
        .RegDst_o   (RegDst_o),
        .MemtoReg_o (MemtoReg_o),
        .RegWrite_o (RegWrite_o),
        .ALUSrcA_o  (ALUSrcA_o),
        .ALUSrcB_o  (ALUSrcB_o),
        .ALUOp_o    (ALUOp_o),
        .PCSource_o (PCSource_o),
`ifdef MC_CTRL_BNE_EN
        .BranchNe_o (BranchNe_o),
`endif
        .trap_o     (trap_o),
        .illegal_o  (illegal_o),
        .timeout_o  (timeout_o)
    );

    // Bit order: PCWrite Branch IRWrite MemRead MemWrite IorD RegDst MemtoReg RegWrite
    //            ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] trap illegal timeout
    logic [18:0] ctl;
    assign ctl = {PCWrite_o, Branch_o, IRWrite_o, MemRead_o, MemWrite_o, IorD_o, RegDst_o,
                  MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o,
                  trap_o, illegal_o, timeout_o};

    localparam logic [18:0] E_IDLE   = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0_0;
    localparam logic [18:0] E_FETCH  = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [18:0] E_FETCHA = 19'b1_0_1_1_0_0_0_0_0_0_01_00_00_0_0_0;
    localparam logic [18:0] E_DECODE = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
    localparam logic [18:0] E_EXEC_R = 19'b0_0_0_0_0_0_0_0_0_1_00_11_00_0_0_0;
    localparam logic [18:0] E_WB_R   = 19'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0_0;
    localparam logic [18:0] E_IMMADD = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
    localparam logic [18:0] E_WB_I   = 19'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0_0;
    localparam logic [18:0] E_MEM_RD = 19'b0_0_0_1_0_1_0_0_0_0_00_00_00_0_0_0;
    localparam logic [18:0] E_MEM_WR = 19'b0_0_0_0_1_1_0_0_0_0_00_00_00_0_0_0;
    localparam logic [18:0] E_WB_MEM = 19'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0_0;
    localparam logic [18:0] E_BEQ    = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_0_0;
    localparam logic [18:0] E_BNE    = 19'b0_0_0_0_0_0_0_0_0_1_00_01_01_0_0_0;
    localparam logic [18:0] E_JUMP   = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0_0;
    localparam logic [18:0] E_TRAPTO = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0_1;
    localparam logic [18:0] E_TRAPIL = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_1_0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [18:0] exp_v);
        #1;
        total++;
        assert (ctl === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, ctl, exp_v);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        rst_i     = 1'b0;
        start_i   = 1'b0;
        mem_ack_i = 1'b0;
        step();
        step();
        chk("reset_idle", E_IDLE);
        rst_i = 1'b1;
    endtask

    // Takes FETCH with immediate ack and lands in DECODE presenting opcode op.
    task automatic fetch_decode(input logic [5:0] op);
        mem_ack_i = 1'b1;
        chk("fetch_ack", E_FETCHA);
        step();
        mem_ack_i = 1'b0;
        Op_i      = op;
        chk("decode", E_DECODE);
    endtask

    initial begin
        Op_i = 6'b0;
        do_reset();

        // R-type, zero-wait memory: FETCH, DECODE, EXEC_R, WB_R then FETCH again
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("r_fetch", E_FETCH);
        fetch_decode(6'b000000);
        step(); chk("r_exec", E_EXEC_R);
        step(); chk("r_wb", E_WB_R);
        step(); chk("r_back_fetch", E_FETCH);

        // lw with three wait cycles on the data access
        fetch_decode(6'b100011);
        step(); chk("lw_addr", E_IMMADD);
        step();
        for (int i = 0; i < 3; i++) begin
            mem_ack_i = 1'b0;
            chk("lw_memrd_wait", E_MEM_RD);
            step();
        end
        mem_ack_i = 1'b1;
        chk("lw_memrd_ack", E_MEM_RD);
        step();
        mem_ack_i = 1'b0;
        chk("lw_wbmem", E_WB_MEM);
        step(); chk("lw_back_fetch", E_FETCH);

        // addi
        fetch_decode(6'b001000);
        step(); chk("addi_exec", E_IMMADD);
        step(); chk("addi_wb", E_WB_I);
        step(); chk("addi_back_fetch", E_FETCH);

        // sw with immediate ack
        fetch_decode(6'b101011);
        step(); chk("sw_addr", E_IMMADD);
        step();
        mem_ack_i = 1'b1;
        chk("sw_memwr", E_MEM_WR);
        step();
        mem_ack_i = 1'b0;
        chk("sw_back_fetch", E_FETCH);

        // beq and j
        fetch_decode(6'b000100);
        step(); chk("beq", E_BEQ);
        chk_bit("beq_no_bne", bne_obs, 1'b0);
        step(); chk("beq_back_fetch", E_FETCH);
        fetch_decode(6'b000010);
        step(); chk("jump", E_JUMP);
        step(); chk("jump_back_fetch", E_FETCH);

        // Reset asserted while MEM_RD waits: back to IDLE, no writeback afterwards
        fetch_decode(6'b100011);
        step(); step();
        chk("rst_pre_memrd", E_MEM_RD);
        rst_i = 1'b0;
        step();
        chk("rst_mid_idle", E_IDLE);
        mem_ack_i = 1'b1;
        rst_i     = 1'b1;
        step(); chk("rst_no_wb_1", E_IDLE);
        step(); chk("rst_no_wb_2", E_IDLE);
        mem_ack_i = 1'b0;

        // Ack arriving in the 16th wait cycle still wins over the timeout
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 15; i++) step();
        mem_ack_i = 1'b1;
        chk("ack_at_limit", E_FETCHA);
        step();
        mem_ack_i = 1'b0;
        chk("ack_at_limit_decode", E_DECODE);
        do_reset();

        // No ack in FETCH: sixteen wait cycles then TRAP with timeout
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 15) chk("timeout_fetch_wait", E_FETCH);
            step();
        end
        chk("timeout_trap", E_TRAPTO);
        step(); chk("timeout_sticky", E_TRAPTO);
        do_reset();

        // Illegal opcode traps; start_i is ignored until reset
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        fetch_decode(6'b111111);
        step(); chk("illegal_trap", E_TRAPIL);
        start_i = 1'b1;
        step(); chk("illegal_start_ignored", E_TRAPIL);
        start_i = 1'b0;
        step(); chk("illegal_sticky", E_TRAPIL);
        do_reset();

        // bne opcode
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        fetch_decode(6'b000101);
        step();
`ifdef MC_CTRL_BNE_EN
        chk("bne_state", E_BNE);
        chk_bit("bne_flag", bne_obs, 1'b1);
        step();
        chk("bne_back_fetch", E_FETCH);
        chk_bit("bne_flag_clear", bne_obs, 1'b0);
`else
        chk("bne_illegal", E_TRAPIL);
        chk_bit("bne_flag_absent", bne_obs, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
